// File: rtl/led_matrix_scanner.sv
// Multiplexed 5x7 LED matrix column scanner: one column lit per slot, with a
// per-frame image snapshot so a displayed frame never mixes old and new data.
module led_matrix_scanner #(
    parameter int CLK_DIV      = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [6:0] col0_rows,
    input  logic [6:0] col1_rows,
    input  logic [6:0] col2_rows,
    input  logic [6:0] col3_rows,
    input  logic [6:0] col4_rows,
    output logic [4:0] columns,
    output logic [6:0] rows,
    output logic       frame_start
);

    localparam int TICK_W = $clog2(CLK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_DIV - 1);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [2:0]        col_idx;
    logic [2:0]        col_nx;
    logic [TICK_W-1:0] tick;
    logic [TICK_W-1:0] tick_nx;
    logic [34:0]       snapshot;
    logic [34:0]       snap_nx;
    logic [34:0]       image;
    logic [6:0]        slice;
    logic              blank;
    logic              show;

    assign image = {col4_rows, col3_rows, col2_rows, col1_rows, col0_rows};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            col_idx  <= 3'd0;
            tick     <= '0;
            snapshot <= '0;
        end else begin
            state    <= state_nx;
            col_idx  <= col_nx;
            tick     <= tick_nx;
            snapshot <= snap_nx;
        end
    end

    // The snapshot only loads on frame entry and on the 4->0 column wrap.
    always_comb begin
        state_nx = state;
        col_nx   = col_idx;
        tick_nx  = tick;
        snap_nx  = snapshot;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nx = SCAN;
                    col_nx   = 3'd0;
                    tick_nx  = '0;
                    snap_nx  = image;
                end
            end
            SCAN: begin
                if (!enable) begin
                    state_nx = IDLE;
                    col_nx   = 3'd0;
                    tick_nx  = '0;
                end else if (tick == TICK_LAST) begin
                    tick_nx = '0;
                    if (col_idx == 3'd4) begin
                        col_nx  = 3'd0;
                        snap_nx = image;
                    end else begin
                        col_nx = col_idx + 3'd1;
                    end
                end else begin
                    tick_nx = tick + TICK_W'(1);
                end
            end
        endcase
    end

    generate
        if (BLANK_CYCLES == 0) begin : g_noblank
            assign blank = 1'b0;
        end else begin : g_blank
            assign blank = (tick < TICK_W'(BLANK_CYCLES));
        end
    endgenerate

    always_comb begin
        slice = 7'd0;
        case (col_idx)
            3'd0:    slice = snapshot[6:0];
            3'd1:    slice = snapshot[13:7];
            3'd2:    slice = snapshot[20:14];
            3'd3:    slice = snapshot[27:21];
            3'd4:    slice = snapshot[34:28];
            default: slice = 7'd0;
        endcase
    end

    // Outputs decode purely from registers, so async reset blanks them at once.
    assign show        = (state == SCAN) && !blank;
    assign columns     = show ? (5'b00001 << col_idx) : 5'b00000;
    assign rows        = show ? slice : 7'd0;
    assign frame_start = (state == SCAN) && (col_idx == 3'd0) && (tick == '0);

endmodule

// File: doc/led_matrix_scanner.md
LED_MATRIX_SCANNER -- requirements
Module: led_matrix_scanner

Interface
REQ-001 The module SHALL have parameter CLK_DIV, default 1000, giving clock cycles per column slot (legal range 2..65535).
REQ-002 The module SHALL have parameter BLANK_CYCLES, default 2, giving blanked cycles at the start of each slot (legal range 0..CLK_DIV-1).
REQ-003 Port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port enable, input, 1 bit: scanning is permitted while high.
REQ-006 Ports col0_rows through col4_rows, input, 7 bits each: row image of matrix columns 0..4, produced by the per-column status decoders; bit n is row n, 1 = LED on.
REQ-007 Port columns, output, 5 bits: one-hot column drive, bit k high selects column k.
REQ-008 Port rows, output, 7 bits: row drive for the selected column, 1 = LED on.
REQ-009 Port frame_start, output, 1 bit: one-cycle pulse marking the first cycle of each frame.

Function
REQ-010 The FSM SHALL have exactly two states: IDLE and SCAN.
REQ-011 Internal state SHALL comprise:
- col_idx: 3 bits, range 0..4.
- tick: counter with range 0..CLK_DIV-1.
- snapshot: 35-bit image register.
REQ-012 All outputs SHALL be decoded only from registered state (state, col_idx, tick, snapshot), never directly from inputs.
REQ-013 In IDLE, outputs SHALL be columns=0, rows=0 and frame_start=0, with col_idx=0 and tick=0.
REQ-014 IDLE SHALL go to SCAN on the first edge with enable=1; on that edge snapshot SHALL load {col4..col0_rows}, col_idx=0 and tick=0.
REQ-015 In SCAN with enable=1, tick SHALL increment each cycle.
REQ-016 In SCAN with enable=1, when tick=CLK_DIV-1, tick SHALL wrap to 0 and col_idx SHALL advance 0->1->2->3->4->0.
REQ-017 On the edge where col_idx wraps 4->0, snapshot SHALL reload from the current inputs; this is the only other snapshot load point, so a frame never shows a mix of old and new images.
REQ-018 In SCAN with tick < BLANK_CYCLES, outputs SHALL be blanked: columns=0 and rows=0.
REQ-019 In SCAN with tick >= BLANK_CYCLES, columns SHALL equal 1<<col_idx and rows SHALL equal the snapshot slice for col_idx.
REQ-020 frame_start SHALL be 1 exactly when state=SCAN, col_idx=0 and tick=0, otherwise 0.
REQ-021 enable=0 while in SCAN SHALL return the FSM to IDLE on the next edge, clearing col_idx and tick; the partial frame is abandoned and snapshot retains its value.
REQ-022 Re-asserting enable SHALL start a new frame at column 0 with a fresh snapshot (per REQ-014), never resuming mid-frame.
REQ-023 Input changes outside load edges SHALL have no effect on outputs.
REQ-024 columns SHALL never have more than one bit set in any cycle.
REQ-025 Frame period SHALL be exactly 5*CLK_DIV cycles while enable stays high.

Reset
REQ-026 rst_n=0 SHALL immediately, independent of clk, force state=IDLE, col_idx=0, tick=0 and snapshot=0, and therefore columns=0, rows=0 and frame_start=0.
REQ-027 Reset asserted mid-slot or mid-frame SHALL blank outputs within the same cycle.
REQ-028 After rst_n deasserts with enable already high, the first rising edge SHALL enter SCAN per REQ-014.

Verification (CLK_DIV=4, BLANK_CYCLES=1 unless noted)
REQ-029 The bench SHALL cover the following directed scenarios:
- Basic frame: enable=1, col0..col4_rows = 7'h01, 7'h02, 7'h04, 7'h08, 7'h7F -> per slot, 1 blank cycle then 3 cycles of columns=00001/rows=01, then 00010/02, 00100/04, 01000/08, 10000/7F; frame_start pulses every 20 cycles.
- Tear-free update: change col2_rows from 04 to 55 while col_idx=1 -> column 2 still shows 04 this frame and shows 55 in the next frame.
- Enable drop: enable=0 at col_idx=3, tick=2 -> next cycle outputs are 0; on re-enable, frame_start pulses and column 0 is displayed after the blank cycle.
- Async reset: pulse rst_n low mid-slot, between clock edges -> outputs go to 0 before the next edge; snapshot reads 0 until the next load.
- No blanking: BLANK_CYCLES=0 -> columns never reads 0 during SCAN; one-hot holds every cycle.
- Wrap and parameter check: CLK_DIV=2 -> col_idx sequence 0,0,1,1,2,2,3,3,4,4,0; snapshot reloads on the 4->0 edge.
